// File: rtl/mealy_seq_detector_pkg.sv
// Shared helpers for the serial-pattern detector: default slot patterns,
// index-width sizing and saturating counter increment.
package mealy_seq_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } ovl_mode_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Slot 1 is the alternating pattern ending in 1 (newest bit = LSB); slot 0
  // is its complement; higher slots default to all-zero.
  function automatic logic [MAX_WIDTH-1:0] default_pattern(input int unsigned width,
                                                          input int unsigned slot);
    logic [MAX_WIDTH-1:0] p;
    p = '0;
    if (slot < 2) begin
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
        if (i < width) p[i] = ((i % 2) == 0) ^ (slot == 0);
      end
    end
    return p;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_inc(input logic [MAX_WIDTH-1:0] v,
                                                  input int unsigned w);
    logic [MAX_WIDTH-1:0] top;
    top = (w >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << w) - 1'b1);
    return (v >= top) ? top : v + 1'b1;
  endfunction

endpackage

// File: rtl/mealy_seq_detector_if.sv
// Serial stream, configuration and result signals of the pattern detector.
interface mealy_seq_detector_if
  import mealy_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned IDX_W   = idx_width(NUM_PAT)
);
  logic                     in_valid;
  logic                     in_bit;
  logic                     cfg_we;
  logic [IDX_W-1:0]         cfg_idx;
  logic [WIDTH-1:0]         cfg_pattern;
  logic                     cfg_overlap;
  logic                     cfg_enable;
  logic                     clear_counts;
  logic [NUM_PAT-1:0]       match;
  logic [NUM_PAT*CNT_W-1:0] match_count;

  modport slave (
    input  in_valid, in_bit, cfg_we, cfg_idx, cfg_pattern, cfg_overlap, cfg_enable,
           clear_counts,
    output match, match_count
  );

  modport master (
    output in_valid, in_bit, cfg_we, cfg_idx, cfg_pattern, cfg_overlap, cfg_enable,
           clear_counts,
    input  match, match_count
  );
endinterface

// File: rtl/mealy_seq_detector_lane.sv
// One pattern slot: configuration registers, non-overlap guard, Mealy compare
// and saturating hit counter.
module mealy_seq_lane
  import mealy_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned SLOT  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] window,
  input  logic             fill_ok,
  input  logic             accept,
  input  logic             clear,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_pattern,
  input  logic             wr_overlap,
  input  logic             wr_enable,
  output logic             match,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned GW = $clog2(WIDTH);
  localparam logic [MAX_WIDTH-1:0] DEF_FULL = default_pattern(WIDTH, SLOT);
  localparam logic [WIDTH-1:0] DEF_PAT = DEF_FULL[WIDTH-1:0];
  localparam logic [GW-1:0] GUARD_INIT = GW'(WIDTH - 1);

  logic [WIDTH-1:0] pat;
  ovl_mode_e        ovl;
  logic             en;
  logic [GW-1:0]    guard;

  always_comb match = accept & ~reset & en & fill_ok & (window == pat) & (guard == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      pat   <= DEF_PAT;
      ovl   <= MODE_OVERLAP;
      en    <= (SLOT < 2);
      guard <= '0;
      count <= '0;
    end else begin
      // Guard counts down the bits still owned by the previous match.
      if (accept) begin
        if (guard != '0)                               guard <= guard - 1'b1;
        else if (match && (ovl == MODE_NONOVERLAP))    guard <= GUARD_INIT;
      end
      if (wr) begin
        pat   <= wr_pattern;
        ovl   <= ovl_mode_e'(wr_overlap);
        en    <= wr_enable;
        guard <= '0;
      end
      if (clear)      count <= '0;
      else if (match) count <= CNT_W'(sat_inc(MAX_WIDTH'(count), CNT_W));
    end
  end
endmodule

// File: rtl/mealy_seq_detector.sv
// Multi-pattern Mealy serial detector: shared history/fill tracking,
// config decode and one lane per programmable pattern.
module mealy_seq_detector
  import mealy_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned IDX_W   = idx_width(NUM_PAT)
) (
  input logic                 clock,
  input logic                 reset,
  mealy_seq_detector_if.slave bus
);
  localparam int unsigned FW = $clog2(WIDTH);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH - 1);

  logic [WIDTH-2:0]         hist;
  logic [FW-1:0]            fill;
  logic [WIDTH-1:0]         window;
  logic                     fill_ok;
  logic [NUM_PAT-1:0]       wr;
  logic [NUM_PAT-1:0]       match_v;
  logic [NUM_PAT*CNT_W-1:0] count_v;

  always_comb begin
    window  = {hist, bus.in_bit};
    fill_ok = (fill == FILL_FULL);
  end

  // Indices at or beyond NUM_PAT match no lane, so such writes are dropped.
  always_comb begin
    wr = '0;
    for (int unsigned k = 0; k < NUM_PAT; k++) begin
      if (bus.cfg_we && (bus.cfg_idx == IDX_W'(k))) wr[k] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (bus.in_valid) begin
      hist <= window[WIDTH-2:0];
      if (fill != FILL_FULL) fill <= fill + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_lane
    mealy_seq_lane #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .SLOT  (k)
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .window     (window),
      .fill_ok    (fill_ok),
      .accept     (bus.in_valid),
      .clear      (bus.clear_counts),
      .wr         (wr[k]),
      .wr_pattern (bus.cfg_pattern),
      .wr_overlap (bus.cfg_overlap),
      .wr_enable  (bus.cfg_enable),
      .match      (match_v[k]),
      .count      (count_v[k*CNT_W +: CNT_W])
    );
  end

  assign bus.match       = match_v;
  assign bus.match_count = count_v;
endmodule

// File: doc/mealy_seq_detector.md
# mealy_seq_detector

Parametrised Mealy serial-pattern detector. It is the successor to the fixed two-pattern, 3-bit "101"/"010" detector. It compares a qualified serial bit stream against NUM_PAT runtime-programmable patterns of WIDTH bits. Each pattern has its own overlap/non-overlap mode, enable and saturating hit counter. It sits directly on a serial input line, and its match outputs feed downstream control logic in the same cycle the final bit arrives.

## Interface
- WIDTH, 3: pattern length in bits, WIDTH >= 2
- NUM_PAT, 2: number of independent patterns, NUM_PAT >= 1
- CNT_W, 8: width of each hit counter
- IDX_W, max(1, $clog2(NUM_PAT)): pattern index width (derived)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  qualifies in_bit; only qualified bits advance the detector
- in_bit  in  1  serial data bit
- cfg_we  in  1  pattern write strobe
- cfg_idx  in  IDX_W  pattern slot to write; out-of-range index is ignored
- cfg_pattern  in  WIDTH  pattern, MSB = oldest bit
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- cfg_enable  in  1  pattern slot enable
- clear_counts  in  1  zero all hit counters
- match  out  NUM_PAT  Mealy match flag per pattern, combinational
- match_count  out  NUM_PAT*CNT_W  hit counters; slot k occupies bits [k*CNT_W +: CNT_W]

## Operation
- History register h[WIDTH-2:0]; h[0] is the newest accepted bit. On each cycle with in_valid=1: h <= {h[WIDTH-3:0], in_bit}.
- Fill counter: saturates at WIDTH-1 and increments on each accepted bit.
- Window = {h, in_bit}.
- match[k] = in_valid & ~reset & en[k] & (fill == WIDTH-1) & (window == pat[k]) & (guard[k] == 0).
- Non-overlap guard, per slot:
  - On a match with ovl[k]=0, guard[k] <= WIDTH-1.
  - On any accepted bit where guard[k] != 0, the match is suppressed and guard[k] decrements.
  - Result: the next match window starts strictly after the previous match bit.
  - With ovl[k]=1, guard stays 0.
- Counter: on match[k], count[k] <= count[k]+1, saturating at 2^CNT_W-1; it never wraps.
- clear_counts zeroes all counters. When a clear coincides with a match, the clear wins and the count becomes 0.
- Config write:
  - pat/ovl/en[cfg_idx] update at the clock edge, and guard[cfg_idx] clears.
  - Matching in the write cycle uses the old configuration.
  - History, fill and counters are unaffected.
- Reset values:
  - h = 0, fill = 0, all guards = 0, all counts = 0.
  - Slot 1 = alternating pattern ending in 1 (WIDTH=3: 101); slot 0 = its complement (010); both enabled, overlap=1. This reproduces the legacy o[1]/o[0] behaviour.
  - Slots >= 2: pattern 0, enable 0, overlap 1.
- Reset mid-stream discards the partial history. A match then needs WIDTH fresh accepted bits.

## Timing
- match is combinational from in_valid/in_bit/state, so latency is 0 cycles. It is valid while in_bit is valid before the rising edge.
- match_count reflects a match from the cycle after the match.
- Config write takes effect for the first accepted bit after its edge.
- While reset=1: match=0. All state takes reset values at the edge.
- The first possible match is on the WIDTH-th accepted bit after reset.
- in_valid=0 cycles: no state change except config writes and clear_counts; match=0.

## Structure
- Package mealy_seq_pkg contains:
  - default-pattern function default_pattern(width, slot)
  - index-width helper
  - counter saturate function
- Sub-module mealy_seq_lane: one per pattern, generated NUM_PAT times. It holds pat/ovl/en, guard, compare and counter, and takes window, fill_ok, accept and clear as inputs.
- The top module holds history, fill, config decode and output packing.

## Test plan
- Defaults, WIDTH=3: accepted bits 1,0,1,0,1 -> match[1] on bits 3 and 5, match[0] on bit 4; then match_count slot1=2, slot0=1.
- Gaps: stream 1,0 then 4 cycles in_valid=0 with in_bit toggling, then 1 -> no match during gap, match[1] on the final bit, slot0 count unchanged.
- Non-overlap: write slot1 = 101, overlap=0. Stream 1,0,1,0,1,0,1 -> match[1] only on bits 3 and 7 (5 suppressed); count=2.
- Saturation, CNT_W=2: six 101 overlapping hits -> count holds at 3. clear_counts coincident with a hit -> count 0 next cycle.
- Config race: write slot0 = 111 in the same cycle as the final bit of 010 -> that cycle match[0]=1 (old config); later 1,1,1 -> match[0]=1.
- Reset mid-stream: 1,0, reset 1 cycle, then 1 -> no match; then 0,1 -> match[1] on the third post-reset bit.
